// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the pipeline: instruction codes, ALU function
// codes, status codes, the "no register" id, condition-code bit positions,
// the M-register layout and its nop value, plus the branch/move condition
// evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [2:0] STAT_AOK = 3'h1;
  localparam logic [2:0] STAT_HLT = 3'h2;
  localparam logic [2:0] STAT_ADR = 3'h3;
  localparam logic [2:0] STAT_INS = 3'h4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } m_reg_t;

  localparam m_reg_t M_NOP = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    vale:  '0,
    vala:  '0,
    dste:  RNONE,
    dstm:  RNONE
  };

  function automatic logic stat_is_exc(input logic [2:0] s);
    return (s == STAT_ADR) || (s == STAT_INS) || (s == STAT_HLT);
  endfunction

  // Condition for jXX / cmovXX; codes 7..15 are never taken.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return (sf ^ of) | zf;
      4'h2:    return sf ^ of;
      4'h3:    return zf;
      4'h4:    return ~zf;
      4'h5:    return ~(sf ^ of);
      4'h6:    return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// 64-bit Y86 ALU.
// Ports: alu_a, alu_b (operands), alu_fun (ADD/SUB/AND/XOR)
//        -> result (B op A, mod 2^64), flags ({ZF,SF,OF}).
// Unknown function codes behave as ADD.
module alu
  import y86_pkg::*;
(
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  input  logic [3:0]  alu_fun,
  output logic [63:0] result,
  output logic [2:0]  flags
);

  logic of;

  always_comb begin
    result = alu_b + alu_a;
    of     = 1'b0;
    case (alu_fun)
      ALU_SUB: begin
        result = alu_b - alu_a;
        // B - A overflows when the operands disagree in sign and the
        // result's sign departs from B.
        of = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      default: begin
        result = alu_b + alu_a;
        of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
      end
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = result[63];
    flags[CC_OF] = of;
  end

endmodule

// File: rtl/exec_stage.sv
// Y86-64 execute stage with the M pipeline register.
// Inputs : clock, reset (sync, active-high), E-register operands e_*,
//          cc (current {ZF,SF,OF}), m_stat / w_stat (downstream status),
//          m_stall / m_bubble (M register control).
// Outputs: new_cc / set_cc (to the CC register), e_vale_fwd / e_dste_fwd
//          (combinational forwarding), M_* (registered M-stage values).
module exec_stage
  import y86_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [63:0] e_valc,
  input  logic [63:0] e_vala,
  input  logic [63:0] e_valb,
  input  logic [3:0]  e_dste,
  input  logic [3:0]  e_dstm,
  input  logic [2:0]  cc,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  w_stat,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic [2:0]  new_cc,
  output logic        set_cc,
  output logic [63:0] e_vale_fwd,
  output logic [3:0]  e_dste_fwd,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_vale,
  output logic [63:0] M_vala,
  output logic [3:0]  M_dste,
  output logic [3:0]  M_dstm
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_fun;
  logic [63:0] alu_result;
  logic        cnd;
  m_reg_t      m_reg_d;
  m_reg_t      m_reg_q;

  always_comb begin
    alu_a = '0;
    case (e_icode)
      I_RRMOVQ, I_OPQ:             alu_a = e_vala;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valc;
      I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               alu_a = 64'd8;
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (e_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = e_valb;
      default: alu_b = '0;
    endcase
  end

  assign alu_fun = (e_icode == I_OPQ) ? e_ifun : ALU_ADD;

  alu u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .result  (alu_result),
    .flags   (new_cc)
  );

  // An exception further down the pipe must not let a younger OPq
  // corrupt the architectural condition codes.
  assign set_cc = (e_icode == I_OPQ) && !stat_is_exc(m_stat) && !stat_is_exc(w_stat);

  assign cnd        = cond_eval(e_ifun, cc);
  assign e_vale_fwd = alu_result;
  // A cmov whose condition fails must not write, so its destination is
  // dropped before both forwarding and the M register.
  assign e_dste_fwd = ((e_icode == I_RRMOVQ) && !cnd) ? RNONE : e_dste;

  always_comb begin
    m_reg_d = m_reg_q;
    if (m_stall) begin
      m_reg_d = m_reg_q;
    end else if (m_bubble) begin
      m_reg_d = M_NOP;
    end else begin
      m_reg_d.stat  = e_stat;
      m_reg_d.icode = e_icode;
      m_reg_d.cnd   = cnd;
      m_reg_d.vale  = alu_result;
      m_reg_d.vala  = e_vala;
      m_reg_d.dste  = e_dste_fwd;
      m_reg_d.dstm  = e_dstm;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_reg_q <= M_NOP;
    end else begin
      m_reg_q <= m_reg_d;
    end
  end

  assign M_stat  = m_reg_q.stat;
  assign M_icode = m_reg_q.icode;
  assign M_cnd   = m_reg_q.cnd;
  assign M_vale  = m_reg_q.vale;
  assign M_vala  = m_reg_q.vala;
  assign M_dste  = m_reg_q.dste;
  assign M_dstm  = m_reg_q.dstm;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus a randomized
// run compared against an arithmetic reference model.
module tb_exec_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valc;
  logic [63:0] e_vala;
  logic [63:0] e_valb;
  logic [3:0]  e_dste;
  logic [3:0]  e_dstm;
  logic [2:0]  cc;
  logic [2:0]  m_stat;
  logic [2:0]  w_stat;
  logic        m_stall;
  logic        m_bubble;
  logic [2:0]  new_cc;
  logic        set_cc;
  logic [63:0] e_vale_fwd;
  logic [3:0]  e_dste_fwd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_vale;
  logic [63:0] M_vala;
  logic [3:0]  M_dste;
  logic [3:0]  M_dstm;

  int checks = 0;
  int passes = 0;

  localparam logic [143:0] NOP_M = {3'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};

  logic [143:0] m_obs;
  assign m_obs = {M_stat, M_icode, M_cnd, M_vale, M_vala, M_dste, M_dstm};

  exec_stage dut (
    .clock(clock), .reset(reset),
    .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_valc(e_valc),
    .e_vala(e_vala), .e_valb(e_valb), .e_dste(e_dste), .e_dstm(e_dstm),
    .cc(cc), .m_stat(m_stat), .w_stat(w_stat),
    .m_stall(m_stall), .m_bubble(m_bubble),
    .new_cc(new_cc), .set_cc(set_cc),
    .e_vale_fwd(e_vale_fwd), .e_dste_fwd(e_dste_fwd),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_vale(M_vale),
    .M_vala(M_vala), .M_dste(M_dste), .M_dstm(M_dstm)
  );

  always #5 clock = ~clock;

  // Reference model: operands and flags from plain signed arithmetic.
  task automatic model(output logic [63:0] res, output logic [2:0] ncc,
                       output logic scc, output logic c, output logic [3:0] dfw);
    logic [63:0] a, b;
    logic signed [64:0] wide;
    logic of;
    int fn;
    logic zf, sf, cof;
    case (e_icode)
      4'h2, 4'h6:       a = e_vala;
      4'h3, 4'h4, 4'h5: a = e_valc;
      4'h8, 4'hA:       a = -64'd8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    b  = (e_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? e_valb : 64'd0;
    fn = (e_icode == 4'h6) ? int'(e_ifun) : 0;
    of = 1'b0;
    if (fn == 1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      res  = wide[63:0];
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end else if (fn == 2) begin
      res = a & b;
    end else if (fn == 3) begin
      res = a ^ b;
    end else begin
      wide = $signed({a[63], a}) + $signed({b[63], b});
      res  = wide[63:0];
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end
    ncc = {res == 64'd0, res[63], of};
    scc = (e_icode == 4'h6) && !(m_stat inside {3'h2, 3'h3, 3'h4})
                            && !(w_stat inside {3'h2, 3'h3, 3'h4});
    zf = cc[2]; sf = cc[1]; cof = cc[0];
    case (e_ifun)
      4'h0: c = 1'b1;
      4'h1: c = (sf != cof) || zf;
      4'h2: c = (sf != cof);
      4'h3: c = zf;
      4'h4: c = !zf;
      4'h5: c = (sf == cof);
      4'h6: c = (sf == cof) && !zf;
      default: c = 1'b0;
    endcase
    dfw = (e_icode == 4'h2 && !c) ? 4'hF : e_dste;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [3:0] dm);
    e_stat = 3'h1; e_icode = ic; e_ifun = fn; e_valc = vc; e_vala = va; e_valb = vb;
    e_dste = de; e_dstm = dm; cc = 3'b000; m_stat = 3'h1; w_stat = 3'h1;
    m_stall = 1'b0; m_bubble = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    drive(4'h6, 4'h0, 64'h0, 64'h11, 64'h22, 4'h3, 4'hF);
    reset = 1'b1; m_stall = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (m_obs !== NOP_M) $display("FAIL reset_state: got %h expected %h", m_obs, NOP_M);
    else passes++;
    reset = 1'b0; m_stall = 1'b0;
  endtask

  task automatic test_sub_zero;
    drive(4'h6, 4'h1, 64'h0, 64'd5, 64'd5, 4'h2, 4'hF);
    #1;
    checks++;
    if (e_vale_fwd !== 64'd0 || new_cc !== 3'b100 || set_cc !== 1'b1)
      $display("FAIL sub_zero_comb: got vale=%h cc=%b set=%b expected 0 100 1",
               e_vale_fwd, new_cc, set_cc);
    else passes++;
    @(posedge clock); #1;
    checks++;
    if (M_vale !== 64'd0 || M_icode !== 4'h6 || M_dste !== 4'h2)
      $display("FAIL sub_zero_m: got vale=%h icode=%h dste=%h expected 0 6 2",
               M_vale, M_icode, M_dste);
    else passes++;
  endtask

  task automatic test_add_overflow;
    drive(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 4'hF);
    #1;
    checks++;
    if (e_vale_fwd !== 64'hFFFF_FFFF_FFFF_FFFE || new_cc !== 3'b011)
      $display("FAIL add_overflow: got vale=%h cc=%b expected fffffffffffffffe 011",
               e_vale_fwd, new_cc);
    else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_rrmov_nocnd;
    drive(4'h2, 4'h3, 64'h0, 64'h1234, 64'h0, 4'h3, 4'hF);
    cc = 3'b000;
    #1;
    checks++;
    if (e_dste_fwd !== 4'hF) $display("FAIL cmov_fwd: got %h expected f", e_dste_fwd);
    else passes++;
    @(posedge clock); #1;
    checks++;
    if (M_dste !== 4'hF || M_cnd !== 1'b0 || M_vale !== 64'h1234)
      $display("FAIL cmov_m: got dste=%h cnd=%b vale=%h expected f 0 1234",
               M_dste, M_cnd, M_vale);
    else passes++;
    cc = 3'b100;
    #1;
    checks++;
    if (e_dste_fwd !== 4'h3) $display("FAIL cmov_taken_fwd: got %h expected 3", e_dste_fwd);
    else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_cc_exc_and_push;
    drive(4'h6, 4'h0, 64'h0, 64'd1, 64'd2, 4'h1, 4'hF);
    m_stat = 3'h3;
    #1;
    checks++;
    if (set_cc !== 1'b0) $display("FAIL set_cc_m_adr: got %b expected 0", set_cc);
    else passes++;
    m_stat = 3'h1; w_stat = 3'h4;
    #1;
    checks++;
    if (set_cc !== 1'b0) $display("FAIL set_cc_w_ins: got %b expected 0", set_cc);
    else passes++;
    drive(4'hA, 4'h0, 64'h0, 64'h77, 64'h100, 4'h4, 4'hF);
    @(posedge clock); #1;
    checks++;
    if (M_vale !== 64'hF8 || M_vala !== 64'h77)
      $display("FAIL pushq_m: got vale=%h vala=%h expected f8 77", M_vale, M_vala);
    else passes++;
  endtask

  task automatic test_stall_bubble;
    logic [143:0] held;
    drive(4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'h4, 4'hF);
    @(posedge clock); #1;
    held = {3'h1, 4'h3, 1'b1, 64'h55, 64'h0, 4'h4, 4'hF};
    checks++;
    if (m_obs !== held) $display("FAIL irmov_load: got %h expected %h", m_obs, held);
    else passes++;
    drive(4'h6, 4'h3, 64'h0, 64'hAA, 64'hBB, 4'h7, 4'h8);
    m_stall = 1'b1; m_bubble = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (m_obs !== held) $display("FAIL stall_hold: got %h expected %h", m_obs, held);
    else passes++;
    m_stall = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (m_obs !== NOP_M) $display("FAIL bubble_nop: got %h expected %h", m_obs, NOP_M);
    else passes++;
    m_bubble = 1'b0;
  endtask

  task automatic test_reset_over_stall;
    drive(4'h6, 4'h0, 64'h0, 64'd1, 64'd2, 4'h5, 4'hF);
    @(posedge clock); #1;
    checks++;
    if (M_vale !== 64'd3) $display("FAIL add_load: got %h expected 3", M_vale);
    else passes++;
    reset = 1'b1; m_stall = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (m_obs !== NOP_M) $display("FAIL reset_over_stall: got %h expected %h", m_obs, NOP_M);
    else passes++;
    reset = 1'b0; m_stall = 1'b0;
  endtask

  task automatic test_random;
    logic [143:0] exp_m;
    logic [63:0]  res;
    logic [2:0]   ncc;
    logic         scc, c;
    logic [3:0]   dfw;
    exp_m = m_obs === NOP_M ? NOP_M : 'x;
    // Start from a known state.
    reset = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    @(posedge clock); #1;
    exp_m = NOP_M;
    for (int i = 0; i < 400; i++) begin
      e_icode  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                             : 4'($urandom_range(0, 11));
      e_ifun   = (e_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      e_stat   = 3'($urandom);
      e_valc   = {$urandom, $urandom};
      e_vala   = ($urandom_range(0, 7) == 0) ? e_valb : {$urandom, $urandom};
      e_valb   = {$urandom, $urandom};
      e_dste   = 4'($urandom);
      e_dstm   = 4'($urandom);
      cc       = 3'($urandom);
      m_stat   = 3'($urandom_range(0, 5));
      w_stat   = 3'($urandom_range(0, 5));
      m_stall  = ($urandom_range(0, 4) == 0);
      m_bubble = ($urandom_range(0, 4) == 0);
      reset    = ($urandom_range(0, 24) == 0);
      #1;
      model(res, ncc, scc, c, dfw);
      checks++;
      if (e_vale_fwd !== res || new_cc !== ncc || set_cc !== scc || e_dste_fwd !== dfw)
        $display("FAIL rand_comb[%0d]: got %h %b %b %h expected %h %b %b %h", i,
                 e_vale_fwd, new_cc, set_cc, e_dste_fwd, res, ncc, scc, dfw);
      else passes++;
      if (reset)         exp_m = NOP_M;
      else if (m_stall)  exp_m = exp_m;
      else if (m_bubble) exp_m = NOP_M;
      else               exp_m = {e_stat, e_icode, c, res, e_vala, dfw, e_dstm};
      @(posedge clock); #1;
      checks++;
      if (m_obs !== exp_m)
        $display("FAIL rand_m[%0d]: got %h expected %h", i, m_obs, exp_m);
      else passes++;
    end
    reset = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
  endtask

  initial begin
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    @(posedge clock); #1;
    test_reset;
    test_sub_zero;
    test_add_overflow;
    test_rrmov_nocnd;
    test_cc_exc_and_push;
    test_stall_bubble;
    test_reset_over_stall;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have ports: clock in 1 (system clock); reset in 1 (synchronous, active-high).
REQ-002 SHALL have ports: e_stat in 3; e_icode in 4; e_ifun in 4; e_valc in 64; e_vala in 64; e_valb in 64; e_dste in 4; e_dstm in 4 (execute-stage operands from E register).
REQ-003 SHALL have ports: cc in 3 (current {ZF,SF,OF} from condition-code register); m_stat in 3 (memory-stage status); w_stat in 3 (write-back status).
REQ-004 SHALL have ports: m_stall in 1 (hold M register); m_bubble in 1 (load nop into M register).
REQ-005 SHALL have ports: new_cc out 3; set_cc out 1 (feed condition-code register).
REQ-006 SHALL have ports: e_vale_fwd out 64; e_dste_fwd out 4 (combinational forwarding to decode).
REQ-007 SHALL have ports: M_stat out 3; M_icode out 4; M_cnd out 1; M_vale out 64; M_vala out 64; M_dste out 4; M_dstm out 4 (registered M-stage outputs).

Function
REQ-008 ALU A operand SHALL be: e_vala for RRMOVQ/OPQ; e_valc for IRMOVQ/RMMOVQ/MRMOVQ; -8 for CALL/PUSHQ; +8 for RET/POPQ; 0 otherwise.
REQ-009 ALU B operand SHALL be: e_valb for RMMOVQ/MRMOVQ/OPQ/CALL/PUSHQ/RET/POPQ; 0 otherwise.
REQ-010 ALU function SHALL be e_ifun when icode=OPQ, else ADD; results: ADD B+A, SUB B-A, AND B&A, XOR B^A, mod 2^64.
REQ-011 new_cc SHALL be {ZF=(result==0), SF=result[63], OF}; OF for ADD: A,B same sign and result sign differs; SUB: A,B signs differ and result sign differs from B; AND/XOR: 0.
REQ-012 set_cc SHALL be 1 iff e_icode=OPQ and m_stat not in {ADR,INS,HLT} and w_stat not in {ADR,INS,HLT}.
REQ-013 cnd SHALL be evaluated from input cc with e_ifun: 0 always; 1 LE (SF^OF)|ZF; 2 L SF^OF; 3 E ZF; 4 NE !ZF; 5 GE !(SF^OF); 6 G !(SF^OF)&!ZF; 7-15 -> 0.
REQ-014 e_dste_fwd SHALL equal RNONE (4'hF) when e_icode=RRMOVQ and cnd=0, else e_dste; e_vale_fwd SHALL equal the ALU result.
REQ-015 At posedge clock, priority reset > m_stall > m_bubble > load.
REQ-016 Load: M register captures {e_stat, e_icode, cnd, ALU result, e_vala, e_dste_fwd, e_dstm}; latency one cycle.
REQ-017 m_stall=1: all M outputs hold value, irrespective of m_bubble.
REQ-018 m_bubble=1 (no stall): M register loads nop state: M_stat=AOK(3'h1), M_icode=NOP(4'h1), M_cnd=0, M_vale=0, M_vala=0, M_dste=M_dstm=RNONE.
REQ-019 new_cc, set_cc, cnd, forwarding outputs SHALL be purely combinational, same cycle as inputs; no state besides M register.

Reset
REQ-020 reset=1 at posedge clock SHALL load nop state of REQ-018, overriding m_stall; outputs reach nop state on that edge.
REQ-021 set_cc SHALL not depend on reset; cc register owns its own reset.
REQ-022 Reset asserted mid-instruction SHALL discard the in-flight M contents; no partial update.

Structure
REQ-023 Shared package y86_pkg SHALL hold icode, ALU-function, condition-code, stat (AOK 1, HLT 2, ADR 3, INS 4) and RNONE constants plus cc bit indices (ZF 2, SF 1, OF 0).
REQ-024 One sub-module alu (operands A,B 64, fun 4 -> result 64, flags 3) SHALL be instantiated; the M register stays inline.

Verification
REQ-025 OPQ SUB, valA=5, valB=5, stats AOK -> result 0, new_cc=3'b100, set_cc=1; next edge M_vale=0.
REQ-026 OPQ ADD, valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> result 64'hFFFF_FFFF_FFFF_FFFE, new_cc=3'b011.
REQ-027 RRMOVQ ifun=3 (E), cc=3'b000, e_dste=3 -> cnd=0, e_dste_fwd=4'hF, M_dste=4'hF after edge.
REQ-028 OPQ with m_stat=ADR -> set_cc=0; PUSHQ valB=64'h100 -> M_vale=64'hF8.
REQ-029 m_stall and m_bubble both 1 -> M holds; then m_bubble only -> M_icode=4'h1, M_dste=4'hF.
REQ-030 reset with m_stall=1 after loading ADD -> M equals nop state next edge.
